// File: rtl/hack_cpu.sv
// Hack CPU core: single-cycle fetch/decode/execute of 16-bit Hack instructions.
// A and D live in load-enabled `register` instances; the PC is a local flop.
// Memory interface outputs are purely combinational from current state and inputs.

// 16-bit load-enabled register with asynchronous active-high reset to zero.
module register (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [15:0] in,
    output logic [15:0] out
);

    logic [15:0] data_q;
    logic [15:0] data_d;

    // Hold the stored value unless load is asserted.
    always_comb begin
        data_d = data_q;
        if (load) begin
            data_d = in;
        end
    end

    // Storage flop; reset takes effect immediately, independent of the clock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q <= 16'h0000;
        end else begin
            data_q <= data_d;
        end
    end

    assign out = data_q;

endmodule

module hack_cpu (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] instruction,
    input  logic [15:0] inM,
    output logic [15:0] outM,
    output logic        writeM,
    output logic [14:0] addressM,
    output logic [14:0] pc
);

    logic        is_c;
    logic        sel_m;
    logic        zx, nx, zy, ny, f, no;
    logic        d1, d2, d3;
    logic        j1, j2, j3;
    logic [1:0]  unused_bits;

    logic [15:0] a_out;
    logic [15:0] d_out;
    logic [15:0] a_in;
    logic        a_load;
    logic        d_load;

    logic [15:0] alu_x;
    logic [15:0] alu_y;
    logic [15:0] alu_raw;
    logic [15:0] alu_out;
    logic        zr;
    logic        ng;
    logic        taken;

    logic [14:0] pc_q;
    logic [14:0] pc_d;

    // Instruction field extraction; bits [14:13] carry no meaning in the ISA.
    assign is_c        = instruction[15];
    assign unused_bits = instruction[14:13];
    assign sel_m       = instruction[12];
    assign zx          = instruction[11];
    assign nx          = instruction[10];
    assign zy          = instruction[9];
    assign ny          = instruction[8];
    assign f           = instruction[7];
    assign no          = instruction[6];
    assign d1          = instruction[5];
    assign d2          = instruction[4];
    assign d3          = instruction[3];
    assign j1          = instruction[2];
    assign j2          = instruction[1];
    assign j3          = instruction[0];

    // Hack ALU: preset/negate each operand, add or AND, optionally invert, then flag.
    always_comb begin
        alu_x   = d_out;
        alu_y   = sel_m ? inM : a_out;
        if (zx) alu_x = 16'h0000;
        if (nx) alu_x = ~alu_x;
        if (zy) alu_y = 16'h0000;
        if (ny) alu_y = ~alu_y;
        alu_raw = f ? (alu_x + alu_y) : (alu_x & alu_y);
        alu_out = no ? ~alu_raw : alu_raw;
        zr      = (alu_out == 16'h0000);
        ng      = alu_out[15];
    end

    // Destination decode: A-instructions load the literal, C-instructions route the ALU.
    always_comb begin
        a_load = 1'b1;
        a_in   = instruction;
        d_load = 1'b0;
        if (is_c) begin
            a_load = d1;
            a_in   = alu_out;
            d_load = d2;
        end
    end

    register u_a_reg (
        .clk  (clk),
        .rst  (rst),
        .load (a_load),
        .in   (a_in),
        .out  (a_out)
    );

    register u_d_reg (
        .clk  (clk),
        .rst  (rst),
        .load (d_load),
        .in   (alu_out),
        .out  (d_out)
    );

    // Jump condition and next-PC selection; the target is A as it stands before the edge.
    always_comb begin
        taken = is_c & ((j1 & ng) | (j2 & zr) | (j3 & ~ng & ~zr));
        pc_d  = pc_q + 15'd1;
        if (taken) begin
            pc_d = a_out[14:0];
        end
    end

    // Program counter flop with immediate reset to the first ROM word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q <= 15'h0000;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc       = pc_q;
    assign outM     = alu_out;
    assign addressM = a_out[14:0];
    assign writeM   = is_c & d3 & ~rst;

endmodule
